// File: rtl/urng_pkg.sv
// Shared constants for the uniform random number generator (taus88).
// WIDTH is the word width. Each component k uses four constants:
//   SHL/SHR build the feedback term b = ((s << SHL) ^ s) >> SHR,
//   MASK and SHC build the next state ((s & MASK) << SHC) ^ b.
package urng_pkg;

    localparam int unsigned WIDTH = 32;

    localparam int unsigned       S0_SHL  = 13;
    localparam int unsigned       S0_SHR  = 19;
    localparam logic [WIDTH-1:0]  S0_MASK = 32'hFFFF_FFFE;
    localparam int unsigned       S0_SHC  = 12;

    localparam int unsigned       S1_SHL  = 2;
    localparam int unsigned       S1_SHR  = 25;
    localparam logic [WIDTH-1:0]  S1_MASK = 32'hFFFF_FFF8;
    localparam int unsigned       S1_SHC  = 4;

    localparam int unsigned       S2_SHL  = 3;
    localparam int unsigned       S2_SHR  = 11;
    localparam logic [WIDTH-1:0]  S2_MASK = 32'hFFFF_FFF0;
    localparam int unsigned       S2_SHC  = 17;

endpackage

// File: rtl/taus_component.sv
// One Tausworthe component of the taus88 generator.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset; loads seed into the state
//   seed  - WIDTH-bit seed, sampled only while rst=1
//   state - current state register value
// Parameters SHL/SHR/MASK/SHC select the component recurrence.
module taus_component
    import urng_pkg::*;
#(
    parameter int unsigned      SHL  = 13,
    parameter int unsigned      SHR  = 19,
    parameter logic [WIDTH-1:0] MASK = 32'hFFFF_FFFE,
    parameter int unsigned      SHC  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] fb;
    logic [WIDTH-1:0] next_state;

    // Logical shifts on a fixed-width word: bits shifted past the MSB are dropped.
    always_comb begin
        fb         = ((state << SHL) ^ state) >> SHR;
        next_state = ((state & MASK) << SHC) ^ fb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/taus.sv
// Combined three-component Tausworthe URNG (taus88). One 32-bit word per clock.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset; loads s0/s1/s2 into the state
//   out - current random word, s0_q ^ s1_q ^ s2_q (no output register)
//   s0  - seed for component 0 (caller keeps s0 > 1)
//   s1  - seed for component 1 (caller keeps s1 > 7)
//   s2  - seed for component 2 (caller keeps s2 > 15)
module taus
    import urng_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2
);

    logic [WIDTH-1:0] s0_q;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    taus_component #(
        .SHL  (S0_SHL),
        .SHR  (S0_SHR),
        .MASK (S0_MASK),
        .SHC  (S0_SHC)
    ) u_comp0 (
        .clk   (clk),
        .rst   (rst),
        .seed  (s0),
        .state (s0_q)
    );

    taus_component #(
        .SHL  (S1_SHL),
        .SHR  (S1_SHR),
        .MASK (S1_MASK),
        .SHC  (S1_SHC)
    ) u_comp1 (
        .clk   (clk),
        .rst   (rst),
        .seed  (s1),
        .state (s1_q)
    );

    taus_component #(
        .SHL  (S2_SHL),
        .SHR  (S2_SHR),
        .MASK (S2_MASK),
        .SHC  (S2_SHC)
    ) u_comp2 (
        .clk   (clk),
        .rst   (rst),
        .seed  (s2),
        .state (s2_q)
    );

    assign out = s0_q ^ s1_q ^ s2_q;

endmodule

// File: tb/tb_taus.sv
// Directed and long-run self-checking bench for the taus88 generator.
module tb_taus;

    logic        clk;
    logic        rst;
    logic [31:0] out;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;

    int unsigned tests;
    int unsigned fails;

    logic [31:0] m0, m1, m2;

    taus dut (
        .clk (clk),
        .rst (rst),
        .out (out),
        .s0  (s0),
        .s1  (s1),
        .s2  (s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] step0(input logic [31:0] x);
        logic [31:0] b;
        b = ((x << 13) ^ x) >> 19;
        return ((x & 32'hFFFFFFFE) << 12) ^ b;
    endfunction

    function automatic logic [31:0] step1(input logic [31:0] x);
        logic [31:0] b;
        b = ((x << 2) ^ x) >> 25;
        return ((x & 32'hFFFFFFF8) << 4) ^ b;
    endfunction

    function automatic logic [31:0] step2(input logic [31:0] x);
        logic [31:0] b;
        b = ((x << 3) ^ x) >> 11;
        return ((x & 32'hFFFFFFF0) << 17) ^ b;
    endfunction

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        rst = 1'b1;
        s0  = a;
        s1  = b;
        s2  = c;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load(32'd2, 32'd8, 32'd16);
        tests++; if (dut.s0_q !== 32'd2) begin fails++; $display("FAIL reset_s0 got %h exp %h", dut.s0_q, 32'd2); end
        tests++; if (dut.s1_q !== 32'd8) begin fails++; $display("FAIL reset_s1 got %h exp %h", dut.s1_q, 32'd8); end
        tests++; if (dut.s2_q !== 32'd16) begin fails++; $display("FAIL reset_s2 got %h exp %h", dut.s2_q, 32'd16); end
        tests++; if (out !== 32'h0000001A) begin fails++; $display("FAIL reset_out got %h exp %h", out, 32'h0000001A); end
    endtask

    task automatic test_step();
        tick();
        tests++; if (dut.s0_q !== 32'h00002000) begin fails++; $display("FAIL step1_s0 got %h exp %h", dut.s0_q, 32'h00002000); end
        tests++; if (dut.s1_q !== 32'h00000080) begin fails++; $display("FAIL step1_s1 got %h exp %h", dut.s1_q, 32'h00000080); end
        tests++; if (dut.s2_q !== 32'h00200000) begin fails++; $display("FAIL step1_s2 got %h exp %h", dut.s2_q, 32'h00200000); end
        tests++; if (out !== 32'h00202080) begin fails++; $display("FAIL step1_out got %h exp %h", out, 32'h00202080); end
        tick();
        tests++; if (dut.s0_q !== 32'h02000080) begin fails++; $display("FAIL step2_s0 got %h exp %h", dut.s0_q, 32'h02000080); end
        tests++; if (dut.s1_q !== 32'h00000800) begin fails++; $display("FAIL step2_s1 got %h exp %h", dut.s1_q, 32'h00000800); end
        tests++; if (dut.s2_q !== 32'h00002400) begin fails++; $display("FAIL step2_s2 got %h exp %h", dut.s2_q, 32'h00002400); end
        tests++; if (out !== 32'h02002C80) begin fails++; $display("FAIL step2_out got %h exp %h", out, 32'h02002C80); end
    endtask

    // Low seed bits are masked out of the shifted term; with these seeds fb is 0.
    task automatic test_mask();
        load(32'd3, 32'd15, 32'd31);
        tests++; if (dut.s0_q !== 32'd3) begin fails++; $display("FAIL mask_load_s0 got %h exp %h", dut.s0_q, 32'd3); end
        tick();
        tests++; if (dut.s0_q !== 32'h00002000) begin fails++; $display("FAIL mask_s0 got %h exp %h", dut.s0_q, 32'h00002000); end
        tests++; if (dut.s1_q !== 32'h00000080) begin fails++; $display("FAIL mask_s1 got %h exp %h", dut.s1_q, 32'h00000080); end
        tests++; if (dut.s2_q !== 32'h00200000) begin fails++; $display("FAIL mask_s2 got %h exp %h", dut.s2_q, 32'h00200000); end
    endtask

    task automatic test_mid_reset();
        load(32'd2, 32'd8, 32'd16);
        m0 = 32'd2; m1 = 32'd8; m2 = 32'd16;
        for (int i = 0; i < 5; i++) begin
            tick();
            m0 = step0(m0); m1 = step1(m1); m2 = step2(m2);
        end
        tests++; if (out !== (m0 ^ m1 ^ m2)) begin fails++; $display("FAIL mid_pre_out got %h exp %h", out, m0 ^ m1 ^ m2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (out !== 32'h0000001A) begin fails++; $display("FAIL mid_reset_out got %h exp %h", out, 32'h0000001A); end
        tick();
        tests++; if (out !== 32'h00202080) begin fails++; $display("FAIL mid_after_out got %h exp %h", out, 32'h00202080); end
    endtask

    task automatic test_seed_ignore();
        load(32'd2, 32'd8, 32'd16);
        s0 = 32'hFFFFFFFF;
        s1 = 32'hA5A5A5A5;
        s2 = 32'h5A5A5A5A;
        tick();
        tests++; if (out !== 32'h00202080) begin fails++; $display("FAIL seed_ignore_out got %h exp %h", out, 32'h00202080); end
        tick();
        tests++; if (out !== 32'h02002C80) begin fails++; $display("FAIL seed_ignore_out2 got %h exp %h", out, 32'h02002C80); end
    endtask

    task automatic test_long_run();
        int unsigned printed;
        printed = 0;
        m0 = $urandom() | 32'h10;
        m1 = $urandom() | 32'h10;
        m2 = $urandom() | 32'h10;
        load(m0, m1, m2);
        s0 = '0; s1 = '0; s2 = '0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            m0 = step0(m0); m1 = step1(m1); m2 = step2(m2);
            tests++;
            if (out !== (m0 ^ m1 ^ m2) || dut.s0_q !== m0 || dut.s1_q !== m1 || dut.s2_q !== m2) begin
                fails++;
                if (printed < 10) begin
                    printed++;
                    $display("FAIL long_run cycle %0d got out=%h s=%h/%h/%h exp out=%h s=%h/%h/%h",
                             i, out, dut.s0_q, dut.s1_q, dut.s2_q, m0 ^ m1 ^ m2, m0, m1, m2);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        s0 = 32'd2;
        s1 = 32'd8;
        s2 = 32'd16;
        test_reset();
        test_step();
        test_mask();
        test_mid_reset();
        test_seed_ignore();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
